// File: rtl/router_pkg.sv
// Shared constants and types for the router output-side control logic.
package router_pkg;

    localparam int unsigned NUM_PORTS       = 3;
    localparam int unsigned ADDR_W          = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 30;

    typedef logic [ADDR_W-1:0]    port_addr_t;
    typedef logic [NUM_PORTS-1:0] port_vec_t;

    // True when the address names an existing destination port.
    function automatic logic addr_in_range(port_addr_t addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr == port_addr_t'(i)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// Header/FIFO control bundle between the input FSM, the FIFOs and the sync controller.
interface router_sync_ctrl_if;
    import router_pkg::*;

    logic       detect_add;
    port_addr_t data_addr;
    logic       write_enb_reg;
    port_vec_t  read_enb;
    port_vec_t  empty;
    port_vec_t  full;
    port_vec_t  write_enb;
    logic       fifo_full;
    port_vec_t  valid_out;
    port_vec_t  soft_reset;
    logic       addr_err;

    // Controller side.
    modport slave (
        input  detect_add,
        input  data_addr,
        input  write_enb_reg,
        input  read_enb,
        input  empty,
        input  full,
        output write_enb,
        output fifo_full,
        output valid_out,
        output soft_reset,
        output addr_err
    );

    // Environment side: input FSM, FIFOs and destination readers.
    modport master (
        output detect_add,
        output data_addr,
        output write_enb_reg,
        output read_enb,
        output empty,
        output full,
        input  write_enb,
        input  fifo_full,
        input  valid_out,
        input  soft_reset,
        input  addr_err
    );

endinterface

// File: rtl/router_timeout_ctr.sv
// Per-port stall watchdog: pulses soft_reset after TIMEOUT consecutive unread valid cycles.
module router_timeout_ctr #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic read,
    output logic soft_reset
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic             stall;

    assign stall = valid && !read;

    // Count stalled edges; on the TIMEOUT-th one fire a pulse and restart from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (!stall) begin
                count_q <= '0;
            end else if (count_q == LAST) begin
                count_q    <= '0;
                soft_reset <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router output-side controller: address latch, write steering, valid and flush generation.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    router_sync_ctrl_if.slave bus
);

    port_addr_t addr_q;
    port_addr_t eff_addr;
    logic       addr_err_q;
    port_vec_t  valid_vec;
    port_vec_t  soft_reset_vec;

    // Header byte bypasses the latch so it can be written in its own cycle.
    assign eff_addr = bus.detect_add ? bus.data_addr : addr_q;

    // Latch the destination address and flag out-of-range headers one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (bus.detect_add) begin
                addr_q <= bus.data_addr;
            end
            addr_err_q <= bus.detect_add && !addr_in_range(bus.data_addr);
        end
    end

    // Decode write enable and full flag; invalid address writes nowhere and never reports full.
    always_comb begin
        bus.write_enb = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (eff_addr == port_addr_t'(i)) begin
                bus.write_enb[i] = bus.write_enb_reg;
                bus.fifo_full    = bus.full[i];
            end
        end
    end

    assign valid_vec      = ~bus.empty;
    assign bus.valid_out  = valid_vec;
    assign bus.addr_err   = addr_err_q;
    assign bus.soft_reset = soft_reset_vec;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT)
        ) u_timeout_ctr (
            .clock      (clock),
            .reset      (reset),
            .valid      (valid_vec[i]),
            .read       (bus.read_enb[i]),
            .soft_reset (soft_reset_vec[i])
        );
    end

endmodule
